rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_frame_pkg.sv | 19 +
 rtl/rx_frame_ctrl_packer.sv | 54 +++++
 rtl/rx_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_frame_pkg.sv
// Shared constants and FSM state encoding for the UART RX frame controller.
// S_CSUM exists only when RX_FRAME_CHECKSUM_EN is defined.
package rx_frame_pkg;

    localparam logic [7:0]  SYNC_BYTE          = 8'hA5;
    localparam int unsigned DEFAULT_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_DATA  = 3'd3,
`ifdef RX_FRAME_CHECKSUM_EN
        S_CSUM  = 3'd4,
`endif
        S_FLUSH = 3'd5
    } state_t;

endpackage

// File: rtl/rx_frame_ctrl_packer.sv
// rx_word_packer: collects payload bytes into a word, first byte at the LSB.
// word_data is valid combinationally in the cycle word_done is high.
module rx_word_packer
    import rx_frame_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            clear,
    input  logic                            load,
    input  logic [DATA_SIZE-1:0]            byte_data,
    output logic                            word_done,
    output logic [WORD_BYTES*DATA_SIZE-1:0] word_data
);

    localparam int unsigned CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [CNT_W-1:0] cnt;

    assign word_done = load && (cnt == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= word_done ? '0 : cnt + CNT_W'(1);
        end
    end

    generate
        if (WORD_BYTES > 1) begin : g_shift
            localparam int unsigned HOLD_W = (WORD_BYTES - 1) * DATA_SIZE;
            logic [HOLD_W-1:0] hold;

            // Bytes enter at the top and walk down, so the oldest lands at the LSB.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    hold <= '0;
                end else if (load && !word_done) begin
                    hold <= HOLD_W'({byte_data, hold} >> DATA_SIZE);
                end
            end

            assign word_data = {byte_data, hold};
        end else begin : g_single
            assign word_data = byte_data;
        end
    endgenerate

endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame decoder: SYNC, ADDR, LEN, payload words -> single-entry valid/ready buffer.
// Optional trailing XOR checksum byte enabled by RX_FRAME_CHECKSUM_EN.
module rx_frame_ctrl
    import rx_frame_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 8,
    parameter int unsigned WORD_BYTES = DEFAULT_WORD_BYTES,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [DATA_SIZE-1:0]            byte_in,
    input  logic                            byte_valid_in,
    output logic [WORD_BYTES*DATA_SIZE-1:0] word_out,
    output logic [ADDR_WIDTH-1:0]           addr_out,
    output logic                            word_valid_out,
    input  logic                            word_ready_in,
    output logic                            frame_done_out,
    output logic                            error_out,
    output logic                            busy_out
);

    localparam int unsigned WORD_W = WORD_BYTES * DATA_SIZE;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [DATA_SIZE-1:0]  len_cnt;
`ifdef RX_FRAME_CHECKSUM_EN
    logic [DATA_SIZE-1:0]  csum;
`endif

    logic              transfer;
    logic              is_sync;
    logic              pack_load;
    logic              pack_clear;
    logic              word_done;
    logic [WORD_W-1:0] word_next;

    assign transfer   = word_valid_out && word_ready_in;
    assign is_sync    = (byte_in == DATA_SIZE'(SYNC_BYTE));
    assign pack_load  = (state == S_DATA) && byte_valid_in;
    assign pack_clear = (state != S_DATA);
    assign busy_out   = (state != S_IDLE);

    rx_word_packer #(
        .DATA_SIZE (DATA_SIZE),
        .WORD_BYTES(WORD_BYTES)
    ) u_packer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (pack_clear),
        .load     (pack_load),
        .byte_data(byte_in),
        .word_done(word_done),
        .word_data(word_next)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            addr_cnt       <= '0;
            len_cnt        <= '0;
            word_out       <= '0;
            addr_out       <= '0;
            word_valid_out <= 1'b0;
            frame_done_out <= 1'b0;
            error_out      <= 1'b0;
`ifdef RX_FRAME_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            frame_done_out <= 1'b0;
            error_out      <= 1'b0;
            // Cleared first so a word landing in the same cycle as a transfer re-sets it.
            if (transfer) begin
                word_valid_out <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (byte_valid_in && is_sync) begin
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (byte_valid_in) begin
                        addr_cnt <= ADDR_WIDTH'(byte_in);
`ifdef RX_FRAME_CHECKSUM_EN
                        csum     <= byte_in;
`endif
                        state    <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (byte_valid_in) begin
                        if (byte_in == '0) begin
                            error_out <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            len_cnt <= byte_in;
`ifdef RX_FRAME_CHECKSUM_EN
                            csum    <= csum ^ byte_in;
`endif
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (byte_valid_in) begin
`ifdef RX_FRAME_CHECKSUM_EN
                        csum <= csum ^ byte_in;
`endif
                        if (word_done) begin
                            if (word_valid_out && !word_ready_in) begin
                                error_out <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                word_out       <= word_next;
                                addr_out       <= addr_cnt;
                                word_valid_out <= 1'b1;
                                addr_cnt       <= addr_cnt + ADDR_WIDTH'(1);
                                len_cnt        <= len_cnt - DATA_SIZE'(1);
                                if (len_cnt == DATA_SIZE'(1)) begin
`ifdef RX_FRAME_CHECKSUM_EN
                                    state <= S_CSUM;
`else
                                    state <= S_FLUSH;
`endif
                                end
                            end
                        end
                    end
                end
`ifdef RX_FRAME_CHECKSUM_EN
                S_CSUM: begin
                    if (byte_valid_in) begin
                        if (byte_in == csum) begin
                            state <= S_FLUSH;
                        end else begin
                            error_out <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
`endif
                S_FLUSH: begin
                    if (!word_valid_out) begin
                        frame_done_out <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl: expected words/pulses queued at stimulus time,
// popped by an independent monitor. Honours RX_FRAME_CHECKSUM_EN like the design.
module tb_rx_frame_ctrl;

    localparam int DS = 8;
    localparam int WB = 4;
    localparam int AW = 8;
    localparam int P_DONE = 0;
    localparam int P_ERR  = 1;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b1;
    logic [DS-1:0]     byte_in = '0;
    logic              byte_valid_in = 1'b0;
    logic [WB*DS-1:0]  word_out;
    logic [AW-1:0]     addr_out;
    logic              word_valid_out;
    logic              word_ready_in = 1'b0;
    logic              frame_done_out;
    logic              error_out;
    logic              busy_out;

    rx_frame_ctrl #(
        .DATA_SIZE (DS),
        .WORD_BYTES(WB),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .word_out      (word_out),
        .addr_out      (addr_out),
        .word_valid_out(word_valid_out),
        .word_ready_in (word_ready_in),
        .frame_done_out(frame_done_out),
        .error_out     (error_out),
        .busy_out      (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WB*DS-1:0] data;
    } exp_word_t;

    exp_word_t exp_words[$];
    int        exp_pulses[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        ready_mode = 1;  // 0: held low, 1: held high, 2: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event, expected none at %0t", name, $time);
    endtask

    // Consumer readiness
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            case (ready_mode)
                0:       word_ready_in = 1'b0;
                1:       word_ready_in = 1'b1;
                default: word_ready_in = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a transfer or pulse
    logic             stall_q = 1'b0;
    logic [WB*DS-1:0] held_word;
    logic [AW-1:0]    held_addr;
    exp_word_t        mon_e;
    int               mon_p;

    initial begin
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                stall_q = 1'b0;
                continue;
            end
            if (stall_q) begin
                check("hold_valid", 64'(word_valid_out), 64'd1);
                check("hold_word", 64'(word_out), 64'(held_word));
                check("hold_addr", 64'(addr_out), 64'(held_addr));
            end
            if (word_valid_out && word_ready_in) begin
                if (exp_words.size() == 0) begin
                    note_fail("word_transfer");
                end else begin
                    mon_e = exp_words.pop_front();
                    check("word_data", 64'(word_out), 64'(mon_e.data));
                    check("word_addr", 64'(addr_out), 64'(mon_e.addr));
                end
            end
            stall_q   = word_valid_out && !word_ready_in;
            held_word = word_out;
            held_addr = addr_out;
            if (frame_done_out) begin
                if (exp_pulses.size() == 0) note_fail("frame_done_pulse");
                else begin
                    mon_p = exp_pulses.pop_front();
                    check("pulse_is_done", 64'(P_DONE), 64'(mon_p));
                end
            end
            if (error_out) begin
                if (exp_pulses.size() == 0) note_fail("error_pulse");
                else begin
                    mon_p = exp_pulses.pop_front();
                    check("pulse_is_error", 64'(P_ERR), 64'(mon_p));
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit wait_empty);
        int guard;
        @(posedge clk_in);
        #1;
        if (wait_empty) begin
            guard = 0;
            while (word_valid_out && guard < 2000) begin
                @(posedge clk_in);
                #1;
                guard++;
            end
            if (guard >= 2000) check("buffer_drain_timeout", 64'(word_valid_out), 64'd0);
        end
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk_in);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy_out && guard < 3000) begin
            @(posedge clk_in);
            #1;
            guard++;
        end
        if (guard >= 3000) check("idle_timeout", 64'(busy_out), 64'd0);
    endtask

    task automatic drive_frame(input logic [7:0] addr, input logic [7:0] len,
                               input logic [7:0] pl[$], input bit bad_csum, input bit wait_empty);
        logic [7:0] g;
        logic [7:0] cs;
        repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            send_byte(g, 1'b0);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(addr, 1'b0);
        send_byte(len, 1'b0);
        foreach (pl[i]) send_byte(pl[i], wait_empty && ((i % WB) == WB - 1));
`ifdef RX_FRAME_CHECKSUM_EN
        if (len != 0) begin
            cs = addr ^ len;
            foreach (pl[i]) cs = cs ^ pl[i];
            if (bad_csum) cs = cs ^ (8'h01 << $urandom_range(0, 7));
            send_byte(cs, 1'b0);
        end
`else
        cs = 8'(bad_csum);
`endif
        wait_idle();
    endtask

    // Reference model: word k = payload bytes [k*WB +: WB], LSB-first, at addr+k mod 2^AW
    task automatic run_frame(input logic [7:0] addr, input logic [7:0] len,
                             input logic [7:0] pl[$], input bit bad_csum, input bit wait_empty);
        exp_word_t e;
        for (int k = 0; k < int'(len); k++) begin
            e.data = '0;
            for (int b = 0; b < WB; b++) e.data = e.data | ((WB*DS)'(pl[k*WB + b]) << (8 * b));
            e.addr = AW'((int'(addr) + k) % 256);
            exp_words.push_back(e);
        end
`ifdef RX_FRAME_CHECKSUM_EN
        if (len == 0 || bad_csum) exp_pulses.push_back(P_ERR);
        else exp_pulses.push_back(P_DONE);
`else
        if (len == 0) exp_pulses.push_back(P_ERR);
        else exp_pulses.push_back(P_DONE);
`endif
        drive_frame(addr, len, pl, bad_csum, wait_empty);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pl[$];
        logic [7:0] a;
        logic [7:0] l;
        bit         bad;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", 64'(word_valid_out), 64'd0);
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_addr", 64'(addr_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_pulses", 64'({frame_done_out, error_out}), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Two-word frame, consumer always ready; words fixed by hand
        ready_mode = 1;
        exp_words.push_back('{addr: 8'h10, data: 32'h04030201});
        exp_words.push_back('{addr: 8'h11, data: 32'h08070605});
        exp_pulses.push_back(P_DONE);
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        drive_frame(8'h10, 8'h02, pl, 1'b0, 1'b0);

        // Address wrap
        exp_words.push_back('{addr: 8'hFF, data: 32'h04030201});
        exp_words.push_back('{addr: 8'h00, data: 32'h08070605});
        exp_pulses.push_back(P_DONE);
        drive_frame(8'hFF, 8'h02, pl, 1'b0, 1'b0);

        // LEN = 0 aborts
        exp_pulses.push_back(P_ERR);
        pl = {};
        drive_frame(8'h00, 8'h00, pl, 1'b0, 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        check("len0_busy", 64'(busy_out), 64'd0);
        check("len0_no_word", 64'(word_valid_out), 64'd0);

        // Overflow with consumer stalled: first word held, second dropped
        ready_mode = 0;
        repeat (2) @(posedge clk_in);
        exp_words.push_back('{addr: 8'h10, data: 32'h04030201});
        exp_pulses.push_back(P_ERR);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        repeat (2) @(posedge clk_in);
        #1;
        check("ovf_valid", 64'(word_valid_out), 64'd1);
        check("ovf_word", 64'(word_out), 64'h04030201);
        check("ovf_addr", 64'(addr_out), 64'h10);
        check("ovf_busy", 64'(busy_out), 64'd0);
        ready_mode = 1;
        repeat (4) @(posedge clk_in);

        // Reset mid-payload
        exp_words.push_back('{addr: 8'h10, data: 32'h04030201});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("midrst_valid", 64'(word_valid_out), 64'd0);
        check("midrst_word", 64'(word_out), 64'd0);
        check("midrst_addr", 64'(addr_out), 64'd0);
        check("midrst_busy", 64'(busy_out), 64'd0);
        check("midrst_pulses", 64'({frame_done_out, error_out}), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_frame(8'h40, 8'h01, pl, 1'b0, 1'b0);

`ifdef RX_FRAME_CHECKSUM_EN
        // Checksum good (0x15) then bad (0x14)
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_words.push_back('{addr: 8'h10, data: 32'h04030201});
        exp_pulses.push_back(P_DONE);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h01, 1'b0);
        foreach (pl[i]) send_byte(pl[i], 1'b0);
        send_byte(8'h15, 1'b0);
        wait_idle();
        exp_words.push_back('{addr: 8'h10, data: 32'h04030201});
        exp_pulses.push_back(P_ERR);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h01, 1'b0);
        foreach (pl[i]) send_byte(pl[i], 1'b0);
        send_byte(8'h14, 1'b0);
        wait_idle();
`endif

        // Randomised frames with a random consumer
        ready_mode = 2;
        for (int f = 0; f < 30; f++) begin
            a   = 8'($urandom);
            l   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            bad = ($urandom_range(0, 3) == 0);
            pl  = {};
            for (int i = 0; i < int'(l) * WB; i++)
                pl.push_back(($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom));
            run_frame(a, l, pl, bad, 1'b1);
        end

        ready_mode = 1;
        repeat (10) @(posedge clk_in);
        #1;
        check("words_drained", 64'(exp_words.size()), 64'd0);
        check("pulses_drained", 64'(exp_pulses.size()), 64'd0);
        check("final_busy", 64'(busy_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
